// File: rtl/ifu_fetch_if.sv
// Fetch-side bus bundle: instruction-memory request/response port plus the
// instruction handshake towards decode. master = fetch unit, slave = its peers.
interface ifu_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_fault,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, inst_fault,
        output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err, inst_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding imem read at a time, registered
// instruction handoff to decode, redirects discard any in-flight response.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    ifu_fetch_if.master bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_pc_q;
    logic        inst_fault_q;
    logic        capture;
    logic [31:0] target;

    assign target = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        inst_valid_d = inst_valid_q;
        capture      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (redirect_valid) pc_d = target;
            end
            ST_REQ: begin
                // The memory port tolerates withdrawal, so an unaccepted
                // request may simply change address on redirect.
                if (bus.imem_req_ready) begin
                    state_d = ST_WAIT;
                    drop_d  = redirect_valid;
                end
                if (redirect_valid) pc_d = target;
            end
            ST_WAIT: begin
                if (bus.imem_resp_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                        if (redirect_valid) pc_d = target;
                    end else begin
                        capture      = 1'b1;
                        inst_valid_d = 1'b1;
                        pc_d         = pc_q + 32'd4;
                        state_d      = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                    pc_d   = target;
                end
            end
            ST_HOLD: begin
                // Redirect wins over inst_ready: the held instruction is flushed.
                if (redirect_valid) begin
                    inst_valid_d = 1'b0;
                    pc_d         = target;
                    state_d      = ST_REQ;
                end else if (bus.inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            inst_valid_q <= inst_valid_d;
            if (capture) begin
                inst_q       <= bus.imem_resp_data;
                inst_pc_q    <= pc_q;
                inst_fault_q <= bus.imem_resp_err;
            end
        end
    end

    assign bus.imem_req_valid = (state_q == ST_REQ);
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.inst_fault     = inst_fault_q;
    assign pc                 = pc_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_ifu_fetch;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] pc;

    ifu_fetch_if bus();

    ifu_fetch #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .pc            (pc),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: has fetch begun, is a read in flight (and is it
    // stale), is an instruction parked for decode.
    bit          m_started, m_out, m_stale, m_hold;
    logic [31:0] m_pc, m_inst, m_ipc;
    logic        m_ifault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_out = 0; m_stale = 0; m_hold = 0;
        m_pc = RST_PC; m_inst = 0; m_ipc = 0; m_ifault = 0;
    endtask

    task automatic model_edge(input logic rv, input logic [31:0] rpc, input logic qr,
                              input logic sv, input logic [31:0] sd, input logic se,
                              input logic ir);
        logic [31:0] tgt;
        tgt = rpc & 32'hFFFF_FFFC;
        if (!m_started) begin
            m_started = 1;
            if (rv) m_pc = tgt;
        end else if (m_hold) begin
            if (rv) begin
                m_hold = 0;
                m_pc = tgt;
            end else if (ir) begin
                m_hold = 0;
            end
        end else if (m_out) begin
            if (sv) begin
                m_out = 0;
                if (m_stale || rv) begin
                    m_stale = 0;
                    if (rv) m_pc = tgt;
                end else begin
                    m_hold = 1; m_inst = sd; m_ipc = m_pc; m_ifault = se;
                    m_pc = m_pc + 32'd4;
                end
            end else if (rv) begin
                m_stale = 1;
                m_pc = tgt;
            end
        end else begin
            if (qr) begin
                m_out = 1;
                m_stale = rv;
            end
            if (rv) m_pc = tgt;
        end
    endtask

    task automatic compare();
        chk("req_valid", bus.imem_req_valid, m_started && !m_out && !m_hold);
        chk("req_addr", bus.imem_req_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("inst_valid", bus.inst_valid, m_hold);
        if (m_hold) begin
            chk("inst", bus.inst, m_inst);
            chk("inst_pc", bus.inst_pc, m_ipc);
            chk("inst_fault", bus.inst_fault, m_ifault);
        end
    endtask

    // Called at a negedge; drives inputs, advances one clock, compares.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic qr,
                        input logic sv, input logic [31:0] sd, input logic se, input logic ir);
        redirect_valid      = rv;
        redirect_pc         = rpc;
        bus.imem_req_ready  = qr;
        bus.imem_resp_valid = sv;
        bus.imem_resp_data  = sd;
        bus.imem_resp_err   = se;
        bus.inst_ready      = ir;
        @(posedge clk);
        model_edge(rv, rpc, qr, sv, sd, se, ir);
        @(negedge clk);
        compare();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_req_valid", bus.imem_req_valid, 1'b0);
        chk("rst_req_addr", bus.imem_req_addr, RST_PC);
        chk("rst_inst_valid", bus.inst_valid, 1'b0);
        chk("rst_inst", bus.inst, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
        chk("rst_inst_fault", bus.inst_fault, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare();
    endtask

    initial begin
        bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_data = 0;
        bus.imem_resp_err = 0; bus.inst_ready = 0;
        @(negedge clk);
        apply_reset();

        // Basic fetch with 1-cycle memory.
        chk("idle_no_req", bus.imem_req_valid, 1'b0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("first_req", bus.imem_req_valid, 1'b1);
        chk("first_addr", bus.imem_req_addr, 32'h8000_0000);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h13, 0, 0);
        chk("d0_inst", bus.inst, 32'h13);
        chk("d0_pc", bus.inst_pc, 32'h8000_0000);
        chk("d0_fault", bus.inst_fault, 1'b0);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("second_addr", bus.imem_req_addr, 32'h8000_0004);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h13, 0, 0);
        chk("d1_pc", bus.inst_pc, 32'h8000_0004);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("third_addr", bus.imem_req_addr, 32'h8000_0008);

        // Decode backpressure.
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h13, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk("bp_valid", bus.inst_valid, 1'b1);
            chk("bp_pc", bus.inst_pc, 32'h8000_0008);
            chk("bp_noreq", bus.imem_req_valid, 1'b0);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        chk("bp_next_addr", bus.imem_req_addr, 32'h8000_000C);

        // Redirect while waiting: response discarded.
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 32'h8000_0103, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0);
        chk("rdw_no_inst", bus.inst_valid, 1'b0);
        chk("rdw_addr", bus.imem_req_addr, 32'h8000_0100);

        // Redirect in HOLD beats inst_ready.
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h1111_2222, 0, 0);
        chk("rdh_pc", bus.inst_pc, 32'h8000_0100);
        step(1, 32'h8000_0010, 0, 0, 0, 0, 1);
        chk("rdh_flushed", bus.inst_valid, 1'b0);
        chk("rdh_addr", bus.imem_req_addr, 32'h8000_0010);

        // Faulting access.
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0, 1, 0);
        chk("flt_fault", bus.inst_fault, 1'b1);
        chk("flt_pc", bus.inst_pc, 32'h8000_0010);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("flt_next", bus.imem_req_addr, 32'h8000_0014);

        // Reset mid-WAIT, then a late response.
        step(0, 0, 1, 0, 0, 0, 0);
        apply_reset();
        step(0, 0, 0, 1, 32'hBAD0_BAD0, 0, 0);
        chk("late_no_inst", bus.inst_valid, 1'b0);
        chk("late_addr", bus.imem_req_addr, 32'h8000_0000);
        step(0, 0, 0, 1, 32'hBAD0_BAD0, 0, 0);
        chk("late_still_req", bus.imem_req_valid, 1'b1);

        // PC wrap.
        step(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        chk("wrap_addr0", bus.imem_req_addr, 32'hFFFF_FFFC);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hAABB_CCDD, 0, 0);
        chk("wrap_ipc", bus.inst_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("wrap_addr1", bus.imem_req_addr, 32'h0000_0000);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                apply_reset();
            end else begin
                logic        rv, qr, sv, se, ir;
                logic [31:0] rpc, sd;
                rv  = ($urandom_range(0, 7) == 0);
                rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom());
                qr  = ($urandom_range(0, 1) == 0);
                sv  = ($urandom_range(0, 4) < 2);
                sd  = 32'($urandom());
                se  = ($urandom_range(0, 9) == 0);
                ir  = ($urandom_range(0, 4) < 3);
                step(rv, rpc, qr, sv, sd, se, ir);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
